// File: rtl/rng_draw_controller.sv
// Runs the external enable counter while a request is held, freezes it on release,
// then reduces the captured sample modulo the requested range with a restoring divider.
module rng_draw_controller #(
    parameter int WIDTH          = 32,
    parameter int OUT_WIDTH      = 8,
    parameter int MIN_RUN_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_req,
    input  logic [OUT_WIDTH-1:0] range,
    input  logic [WIDTH-1:0]     counter_value,
    output logic                 counter_enable,
    output logic [WIDTH-1:0]     raw_value,
    output logic [OUT_WIDTH-1:0] result,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic                 busy,
    output logic                 error
);
    localparam int RUN_W = $clog2(MIN_RUN_CYCLES + 1);
    localparam int BIT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, RUN, CAPTURE, REDUCE, PRESENT} state_t;

    state_t               state, state_next;
    logic [RUN_W-1:0]     run_cnt, run_inc;
    logic [BIT_W-1:0]     bit_cnt;
    logic [WIDTH-1:0]     dividend;
    logic [OUT_WIDTH-1:0] range_q;
    logic [OUT_WIDTH-1:0] rem, rem_next;
    logic [OUT_WIDTH:0]   rem_shift;
    logic                 err_lock;

    // Saturating count of RUN cycles including the current one.
    assign run_inc = (run_cnt == RUN_W'(MIN_RUN_CYCLES)) ? run_cnt : run_cnt + 1'b1;

    // One restoring-division step; the remainder always fits back into OUT_WIDTH bits.
    assign rem_shift = {rem, dividend[WIDTH-1]};
    assign rem_next  = OUT_WIDTH'((rem_shift >= {1'b0, range_q}) ? rem_shift - {1'b0, range_q}
                                                                  : rem_shift);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_req && range != '0) state_next = RUN;
            RUN:     if (!start_req && run_inc == RUN_W'(MIN_RUN_CYCLES)) state_next = CAPTURE;
            CAPTURE: state_next = REDUCE;
            REDUCE:  if (bit_cnt == BIT_W'(WIDTH - 1)) state_next = PRESENT;
            PRESENT: if (result_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            run_cnt   <= '0;
            bit_cnt   <= '0;
            dividend  <= '0;
            range_q   <= '0;
            rem       <= '0;
            raw_value <= '0;
            result    <= '0;
            error     <= 1'b0;
            err_lock  <= 1'b0;
        end else begin
            state <= state_next;
            error <= (state == IDLE) && start_req && (range == '0) && !err_lock;
            // A zero-range request reports once until the request is released.
            if (!start_req)
                err_lock <= 1'b0;
            else if (state == IDLE && range == '0)
                err_lock <= 1'b1;

            case (state)
                IDLE: begin
                    if (start_req && range != '0) begin
                        range_q <= range;
                        run_cnt <= '0;
                    end
                end
                RUN: run_cnt <= run_inc;
                CAPTURE: begin
                    raw_value <= counter_value;
                    dividend  <= counter_value;
                    rem       <= '0;
                    bit_cnt   <= '0;
                end
                REDUCE: begin
                    rem      <= rem_next;
                    dividend <= dividend << 1;
                    bit_cnt  <= bit_cnt + 1'b1;
                    if (state_next == PRESENT) result <= rem_next;
                end
                default: ;
            endcase
        end
    end

    assign counter_enable = (state == RUN);
    assign busy           = (state != IDLE);
    assign result_valid   = (state == PRESENT);
endmodule

// File: tb/tb_rng_draw_controller.sv
// Directed bench for rng_draw_controller: a cycle-level draw model checked every
// cycle, plus literal expectations for each scenario.
module tb_rng_draw_controller;
    localparam int WIDTH = 32;
    localparam int OW    = 8;
    localparam int MIN   = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            start_req;
    logic [OW-1:0]   range;
    logic [WIDTH-1:0] counter_value;
    logic            counter_enable;
    logic [WIDTH-1:0] raw_value;
    logic [OW-1:0]   result;
    logic            result_valid;
    logic            result_ready;
    logic            busy;
    logic            error;

    int n_chk  = 0;
    int n_fail = 0;
    int en_cnt = 0;
    int err_cnt = 0;
    int lat;

    rng_draw_controller #(.WIDTH(WIDTH), .OUT_WIDTH(OW), .MIN_RUN_CYCLES(MIN)) dut (
        .clk(clk), .reset(reset), .start_req(start_req), .range(range),
        .counter_value(counter_value), .counter_enable(counter_enable),
        .raw_value(raw_value), .result(result), .result_valid(result_valid),
        .result_ready(result_ready), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    // Enable counter: loads 1 on the first enabled edge, then increments.
    logic [WIDTH-1:0] cnt;
    logic             cnt_prev_en;
    logic             force_ff;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            cnt_prev_en <= 1'b0;
        end else begin
            cnt_prev_en <= counter_enable;
            if (counter_enable) cnt <= cnt_prev_en ? cnt + 1 : 1;
        end
    end
    assign counter_value = force_ff ? 32'hFFFF_FFFF : cnt;

    // Draw model: phase 0 idle, 1 counter running, 2 capture+divide countdown, 3 presenting.
    int              m_phase, m_run, m_cd;
    logic [OW-1:0]   m_rng, m_res;
    logic [WIDTH-1:0] m_raw;
    logic            m_err, m_lock;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase <= 0; m_run <= 0; m_cd <= 0; m_rng <= '0; m_res <= '0;
            m_raw <= '0; m_err <= 1'b0; m_lock <= 1'b0;
        end else begin
            m_err <= (m_phase == 0) && start_req && (range == 0) && !m_lock;
            if (!start_req) m_lock <= 1'b0;
            else if (m_phase == 0 && range == 0) m_lock <= 1'b1;
            case (m_phase)
                0: if (start_req && range != 0) begin
                       m_phase <= 1; m_rng <= range; m_run <= 0;
                   end
                1: begin
                       m_run <= m_run + 1;
                       if (!start_req && m_run + 1 >= MIN) begin
                           m_phase <= 2; m_cd <= WIDTH + 1;
                       end
                   end
                2: begin
                       if (m_cd == WIDTH + 1) m_raw <= counter_value;
                       if (m_cd == 1) begin
                           m_phase <= 3; m_res <= OW'(m_raw % m_rng);
                       end
                       m_cd <= m_cd - 1;
                   end
                default: if (result_ready) m_phase <= 0;
            endcase
        end
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("counter_enable", WIDTH'(counter_enable), WIDTH'(m_phase == 1));
        check("busy",           WIDTH'(busy),           WIDTH'(m_phase != 0));
        check("result_valid",   WIDTH'(result_valid),   WIDTH'(m_phase == 3));
        check("error",          WIDTH'(error),          WIDTH'(m_err));
        check("raw_value",      raw_value,              m_raw);
        check("result",         WIDTH'(result),         WIDTH'(m_res));
        if (counter_enable) en_cnt++;
        if (error) err_cnt++;
    end

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!result_valid && n < 300);
        check("valid_timeout", WIDTH'(result_valid), 1);
    endtask

    // Hold the request for the given number of sampled edges, then release.
    task automatic draw(input logic [OW-1:0] r, input int hold);
        en_cnt = 0;
        range = r;
        start_req = 1'b1;
        repeat (hold) @(posedge clk);
        #1 start_req = 1'b0;
    endtask

    task automatic ack();
        result_ready = 1'b1;
        @(posedge clk);
        #1 result_ready = 1'b0;
        @(negedge clk);
        check("valid_after_ack", WIDTH'(result_valid), 0);
        check("busy_after_ack",  WIDTH'(busy), 0);
    endtask

    initial begin
        reset = 1'b1; start_req = 1'b0; range = '0; result_ready = 1'b0; force_ff = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_enable", WIDTH'(counter_enable), 0);
        check("rst_busy",   WIDTH'(busy), 0);
        check("rst_valid",  WIDTH'(result_valid), 0);
        check("rst_result", WIDTH'(result), 0);
        check("rst_raw",    raw_value, 0);
        #2 reset = 1'b0;
        @(posedge clk); #1;

        // Long hold: 100 enabled cycles, 100 mod 6 = 4, valid 34 cycles after release sample.
        draw(6, 100);
        @(posedge clk);
        wait_valid(lat);
        check("lat_100", WIDTH'(lat), 34);
        check("en_100", WIDTH'(en_cnt), 100);
        check("raw_100", raw_value, 100);
        check("res_100", WIDTH'(result), 4);
        check("busy_present", WIDTH'(busy), 1);
        ack();

        // Short pulse: minimum run of 16, 16 mod 10 = 6; stall consumer and change range.
        draw(10, 3);
        wait_valid(lat);
        check("en_16", WIDTH'(en_cnt), 16);
        check("raw_16", raw_value, 16);
        check("res_16", WIDTH'(result), 6);
        range = 3;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("stall_valid", WIDTH'(result_valid), 1);
            check("stall_result", WIDTH'(result), 6);
        end
        ack();
        check("res_retained", WIDTH'(result), 6);

        // Zero range: one error pulse per request, no run.
        en_cnt = 0; err_cnt = 0;
        range = 0; start_req = 1'b1;
        repeat (6) @(negedge clk);
        check("err_once", WIDTH'(err_cnt), 1);
        check("err_no_run", WIDTH'(en_cnt), 0);
        check("err_idle", WIDTH'(busy), 0);
        start_req = 1'b0;
        repeat (2) @(negedge clk);
        start_req = 1'b1;
        repeat (3) @(negedge clk);
        check("err_rearm", WIDTH'(err_cnt), 2);
        start_req = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of the reduction aborts the draw immediately.
        draw(9, 20);
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_enable", WIDTH'(counter_enable), 0);
        check("abort_busy",   WIDTH'(busy), 0);
        check("abort_valid",  WIDTH'(result_valid), 0);
        check("abort_raw",    raw_value, 0);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        draw(7, 50);
        wait_valid(lat);
        check("en_50", WIDTH'(en_cnt), 50);
        check("raw_50", raw_value, 50);
        check("res_50", WIDTH'(result), 1);
        ack();

        // Pre-wrapped counter sample.
        force_ff = 1'b1;
        draw(255, 20);
        wait_valid(lat);
        check("raw_ff", raw_value, 32'hFFFF_FFFF);
        check("res_ff_255", WIDTH'(result), 0);
        ack();
        draw(100, 20);
        wait_valid(lat);
        check("res_ff_100", WIDTH'(result), 95);
        ack();
        force_ff = 1'b0;

        // range=1 always yields 0.
        draw(1, 37);
        wait_valid(lat);
        check("raw_37", raw_value, 37);
        check("res_mod1", WIDTH'(result), 0);
        ack();

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rng_draw_controller.md
Name: rng_draw_controller

Overview:
- Sequences the free-running enable counter into a bounded random draw.
- While the user request is held, it drives the counter's enable. On release, after a guaranteed minimum run, it freezes the counter and captures its value.
- Reduces the captured value modulo a requested range with a multi-cycle shift-subtract divider.
- Presents the result on a valid/ready handshake to the display/output logic.

Parameters:
- WIDTH, 32, width of counter_value and of the captured raw sample
- OUT_WIDTH, 8, width of range and result
- MIN_RUN_CYCLES, 16, minimum number of cycles counter_enable stays high per draw (>=1)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- start_req  input  1  level request (debounced button); held high = counter runs
- range  input  OUT_WIDTH  modulus N of the draw; result in [0, N-1]; sampled only in IDLE
- counter_value  input  WIDTH  registered count from the enable counter
- counter_enable  output  1  drives the counter's enable input
- raw_value  output  WIDTH  last captured counter sample (debug)
- result  output  OUT_WIDTH  counter sample mod range
- result_valid  output  1  result available
- result_ready  input  1  consumer accepts result
- busy  output  1  high in every state except IDLE
- error  output  1  one-cycle pulse: start requested with range==0

Behaviour:
- Reset (async, immediate): state=IDLE. counter_enable, result_valid, busy and error are 0; result=0, raw_value=0, internal run counter and remainder cleared. Reset mid-draw aborts the draw; no partial result is ever presented.
- Counter contract: the counter loads 1 on the first enabled edge and increments on each further enabled edge. After K cycles of counter_enable=1 it reads K, modulo 2^WIDTH.
- All outputs are registered from state; counter_enable=1 exactly in RUN.
- IDLE:
  - start_req=1 and range!=0: latch range into range_q, clear run_cnt, go to RUN.
  - start_req=1 and range==0: error=1 for one cycle, stay IDLE. The request must fall and rise again before error pulses again.
- RUN:
  - counter_enable=1; run_cnt increments, saturating at MIN_RUN_CYCLES.
  - Exit to CAPTURE at the end of a RUN cycle in which start_req=0 and run_cnt (already counting that cycle) >= MIN_RUN_CYCLES.
  - A release before the minimum run keeps RUN until MIN_RUN_CYCLES cycles are complete. Therefore counter_enable is high for max(MIN_RUN_CYCLES, held cycles) cycles.
- CAPTURE (1 cycle): counter_enable=0, so the counter is frozen. Latch counter_value into raw_value and into the dividend shift register; clear the remainder.
- REDUCE (exactly WIDTH cycles), each cycle MSB first:
  - rem = {rem, dividend_msb}
  - if rem >= range_q, then rem -= range_q
  - rem is OUT_WIDTH+1 bits wide to hold the pre-subtract value.
- PRESENT:
  - result = rem[OUT_WIDTH-1:0]; result_valid=1 and held stable until result_ready=1.
  - On the handshake cycle, go to IDLE; result_valid drops the next cycle and result retains its value.
  - result_ready while not valid is ignored.
- Latency: if start_req is sampled low (minimum met) at edge t, CAPTURE occupies t+1, REDUCE occupies t+2..t+WIDTH+1, and result_valid=1 from t+WIDTH+2.
- Boundary rules:
  - range or start_req changes outside IDLE are ignored.
  - A start_req held high while in PRESENT does not start a new draw.
  - A new draw after returning to IDLE needs start_req=1 sampled in IDLE.
  - Counter wrap-around to 0 needs no special handling: 0 mod N = 0.
  - range=1 always yields result 0.

Test Plan:
- MIN_RUN_CYCLES=16, range=6, start_req high for 100 cycles then low -> counter_enable high exactly 100 cycles; raw_value=100; result=4; result_valid rises 34 cycles after the release sample; busy is high throughout.
- start_req pulsed for 3 cycles, range=10 -> counter_enable high 16 cycles; raw_value=16; result=6.
- range=0 with start_req=1 -> error pulses once for 1 cycle; counter_enable stays 0; state remains IDLE.
- result_ready held low for 20 cycles in PRESENT -> result_valid and result stable; range changed to 3 during this wait has no effect. Assert ready -> result_valid drops the next cycle and busy drops.
- Reset asserted mid-REDUCE -> counter_enable, busy and result_valid go 0 immediately. A next draw with range=7 for 50 cycles gives raw_value=50 and result=1.
- Counter pre-wrapped: model counter_value=32'hFFFF_FFFF at capture with range=255 -> result=0; with range=100 -> result=95.
